// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: round-robin arbitration of ALU/LSU results onto
// the single RF write port, plus the per-register busy scoreboard used for RAW stalls.
module rf_wb_ctrl #(
  parameter  int DATA_WIDTH    = 32,
  parameter  int NUM_REGISTERS = 32,
  localparam int ADDRESS_WIDTH = $clog2(NUM_REGISTERS)
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     flush_in,
  input  logic                     issue_valid_in,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd_in,
  input  logic                     alu_valid_in,
  output logic                     alu_ready_out,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd_in,
  input  logic [DATA_WIDTH-1:0]    alu_data_in,
  input  logic                     lsu_valid_in,
  output logic                     lsu_ready_out,
  input  logic [ADDRESS_WIDTH-1:0] lsu_rd_in,
  input  logic [DATA_WIDTH-1:0]    lsu_data_in,
  output logic                     wr_en_out,
  output logic [ADDRESS_WIDTH-1:0] rd_out,
  output logic [DATA_WIDTH-1:0]    rd_data_out,
  output logic [NUM_REGISTERS-1:0] busy_out
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  src_e                     rr_last;
  logic                     alu_xfer;
  logic                     lsu_xfer;
  logic                     xfer;
  logic [ADDRESS_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic [NUM_REGISTERS-1:0] busy_next;

  // Under contention the source that did not win last time gets the port.
  assign alu_ready_out = alu_valid_in && (!lsu_valid_in || rr_last == SRC_LSU);
  assign lsu_ready_out = lsu_valid_in && (!alu_valid_in || rr_last == SRC_ALU);

  assign alu_xfer = alu_valid_in && alu_ready_out;
  assign lsu_xfer = lsu_valid_in && lsu_ready_out;
  assign xfer     = alu_xfer || lsu_xfer;
  assign wb_rd    = lsu_xfer ? lsu_rd_in   : alu_rd_in;
  assign wb_data  = lsu_xfer ? lsu_data_in : alu_data_in;

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred; later statements override earlier ones.
  always_comb begin
    busy_next = busy_out;
    if (xfer && wb_rd != '0)
      busy_next[wb_rd] = 1'b0;
    if (issue_valid_in && issue_rd_in != '0)
      busy_next[issue_rd_in] = 1'b1;
    if (flush_in)
      busy_next = '0;
    busy_next[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_last     <= SRC_ALU;
      wr_en_out   <= 1'b0;
      rd_out      <= '0;
      rd_data_out <= '0;
      busy_out    <= '0;
    end else begin
      busy_out  <= busy_next;
      wr_en_out <= xfer && wb_rd != '0;
      if (xfer) begin
        rr_last     <= lsu_xfer ? SRC_LSU : SRC_ALU;
        rd_out      <= wb_rd;
        rd_data_out <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: directed vector table, reset-mid-write sequence,
// then constrained-random traffic against a behavioural model of grants, writes and busy bits.
module tb_rf_wb_ctrl;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          flush_in = 1'b0;
  logic          issue_valid_in = 1'b0;
  logic [AW-1:0] issue_rd_in = '0;
  logic          alu_valid_in = 1'b0;
  logic          alu_ready_out;
  logic [AW-1:0] alu_rd_in = '0;
  logic [DW-1:0] alu_data_in = '0;
  logic          lsu_valid_in = 1'b0;
  logic          lsu_ready_out;
  logic [AW-1:0] lsu_rd_in = '0;
  logic [DW-1:0] lsu_data_in = '0;
  logic          wr_en_out;
  logic [AW-1:0] rd_out;
  logic [DW-1:0] rd_data_out;
  logic [NR-1:0] busy_out;

  rf_wb_ctrl #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR)) dut (
    .clk(clk), .arst_n(arst_n), .flush_in(flush_in),
    .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in),
    .alu_valid_in(alu_valid_in), .alu_ready_out(alu_ready_out),
    .alu_rd_in(alu_rd_in), .alu_data_in(alu_data_in),
    .lsu_valid_in(lsu_valid_in), .lsu_ready_out(lsu_ready_out),
    .lsu_rd_in(lsu_rd_in), .lsu_data_in(lsu_data_in),
    .wr_en_out(wr_en_out), .rd_out(rd_out), .rd_data_out(rd_data_out),
    .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          iv;  logic [AW-1:0] ird;
    logic          av;  logic [AW-1:0] ard; logic [DW-1:0] ad;
    logic          lv;  logic [AW-1:0] lrd; logic [DW-1:0] ld;
    logic          fl;
    logic          ea;  logic el; logic ew;
    logic [AW-1:0] erd; logic [DW-1:0] edat; logic [NR-1:0] ebusy;
  } vec_t;

  vec_t vecs[14];

  task automatic drive(input logic iv, input logic [AW-1:0] ird,
                       input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                       input logic fl);
    issue_valid_in = iv; issue_rd_in = ird;
    alu_valid_in = av; alu_rd_in = ard; alu_data_in = ad;
    lsu_valid_in = lv; lsu_rd_in = lrd; lsu_data_in = ld;
    flush_in = fl;
  endtask

  // Reference model state: who was granted last (0 = ALU, 1 = LSU) and pending writes.
  int            m_last;
  logic [NR-1:0] m_busy;
  logic          m_wr;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;

  initial begin
    logic    ga, gl;
    logic    a_v, l_v;
    logic [AW-1:0] a_rd, l_rd;
    logic [DW-1:0] a_d, l_d;

    vecs[0]  = '{1,5, 0,0,0,            0,0,0,    0, 0,0,0, 0,0,            32'h20};
    vecs[1]  = '{0,0, 1,5,32'hDEADBEEF, 0,0,0,    0, 1,0,1, 5,32'hDEADBEEF, 32'h0};
    vecs[2]  = '{0,0, 1,1,32'h11,       1,2,32'h22, 0, 0,1,1, 2,32'h22,     32'h0};
    vecs[3]  = '{0,0, 1,1,32'h11,       1,2,32'h33, 0, 1,0,1, 1,32'h11,     32'h0};
    vecs[4]  = '{0,0, 1,1,32'h44,       1,2,32'h33, 0, 0,1,1, 2,32'h33,     32'h0};
    vecs[5]  = '{0,0, 1,1,32'h44,       1,2,32'h55, 0, 1,0,1, 1,32'h44,     32'h0};
    vecs[6]  = '{0,0, 0,0,0,            1,2,32'h55, 0, 0,1,1, 2,32'h55,     32'h0};
    vecs[7]  = '{1,7, 0,0,0,            1,0,32'h66, 0, 0,1,0, 0,0,          32'h80};
    vecs[8]  = '{1,7, 1,7,32'h77,       0,0,0,    0, 1,0,1, 7,32'h77,       32'h80};
    vecs[9]  = '{1,4, 0,0,0,            0,0,0,    0, 0,0,0, 0,0,            32'h90};
    vecs[10] = '{1,5, 0,0,0,            0,0,0,    0, 0,0,0, 0,0,            32'hB0};
    vecs[11] = '{1,6, 0,0,0,            0,0,0,    0, 0,0,0, 0,0,            32'hF0};
    vecs[12] = '{1,9, 1,4,32'hAB,       0,0,0,    1, 1,0,1, 4,32'hAB,       32'h0};
    vecs[13] = '{0,0, 0,0,0,            0,0,0,    0, 0,0,0, 0,0,            32'h0};

    // Reset state
    #12;
    check("rst_wr_en", wr_en_out, 0);
    check("rst_rd", rd_out, 0);
    check("rst_data", rd_data_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_alu_ready", alu_ready_out, 0);
    check("rst_lsu_ready", lsu_ready_out, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].ird, vecs[i].av, vecs[i].ard, vecs[i].ad,
            vecs[i].lv, vecs[i].lrd, vecs[i].ld, vecs[i].fl);
      #1;
      check($sformatf("v%0d_alu_ready", i), alu_ready_out, vecs[i].ea);
      check($sformatf("v%0d_lsu_ready", i), lsu_ready_out, vecs[i].el);
      @(posedge clk); #1;
      check($sformatf("v%0d_wr_en", i), wr_en_out, vecs[i].ew);
      if (vecs[i].ew) begin
        check($sformatf("v%0d_rd", i), rd_out, vecs[i].erd);
        check($sformatf("v%0d_data", i), rd_data_out, vecs[i].edat);
      end
      check($sformatf("v%0d_busy", i), busy_out, vecs[i].ebusy);
    end

    // Reset asserted while a write sits in the output stage
    @(negedge clk);
    drive(1, 3, 1, 3, 32'hCAFE0003, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("mid_wr_en_before", wr_en_out, 1);
    check("mid_busy_before", busy_out, 32'h8);
    #2 arst_n = 1'b0;
    #1;
    check("mid_wr_en_async", wr_en_out, 0);
    check("mid_busy_async", busy_out, 0);
    check("mid_rd_async", rd_out, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("mid_alu_ready_idle", alu_ready_out, 0);
    check("mid_lsu_ready_idle", lsu_ready_out, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Randomized traffic against the model
    m_last = 0; m_busy = '0; m_wr = 0; m_rd = '0; m_data = '0;
    a_v = 0; l_v = 0; a_rd = '0; l_rd = '0; a_d = '0; l_d = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      drive($urandom_range(0, 2) == 0, AW'($urandom_range(0, NR - 1)),
            a_v, a_rd, a_d, l_v, l_rd, l_d, $urandom_range(0, 40) == 0);
      if (a_v && l_v) begin
        ga = (m_last == 1);
        gl = (m_last == 0);
      end else begin
        ga = a_v;
        gl = l_v;
      end
      #1;
      check("rnd_alu_ready", alu_ready_out, ga);
      check("rnd_lsu_ready", lsu_ready_out, gl);

      // Model update for this edge
      m_wr = 0;
      if (ga || gl) begin
        m_rd   = gl ? l_rd : a_rd;
        m_data = gl ? l_d : a_d;
        m_wr   = (m_rd != 0);
        m_last = gl ? 1 : 0;
        if (m_rd != 0) m_busy[m_rd] = 1'b0;
      end
      if (issue_valid_in && issue_rd_in != 0) m_busy[issue_rd_in] = 1'b1;
      if (flush_in) m_busy = '0;

      @(posedge clk); #1;
      check("rnd_wr_en", wr_en_out, m_wr);
      if (m_wr) begin
        check("rnd_rd", rd_out, m_rd);
        check("rnd_data", rd_data_out, m_data);
      end
      check("rnd_busy", busy_out, m_busy);

      // Producers hold an unaccepted request, otherwise pick a fresh one
      if (!a_v || ga) begin
        a_v = $urandom_range(0, 1) == 1;
        a_rd = AW'($urandom_range(0, NR - 1));
        a_d = $urandom;
      end
      if (!l_v || gl) begin
        l_v = $urandom_range(0, 1) == 1;
        l_rd = AW'($urandom_range(0, NR - 1));
        l_d = $urandom;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
